// File: rtl/tx_framer.sv
// ----------------------------------------------------------------------------
// tx_framer
//
// Packs pairs of payload bytes into 32-bit frame words {SYNC, P0, P1, CK}
// for a serial modulator. CK = (P0 + P1) mod 256. It issues a one-cycle
// start pulse per frame. After the pulse, the framer holds off for the
// transmit time plus a guard interval before it issues the next frame.
//
// Ports
//   clk          single clock, rising edge
//   reset        asynchronous, active-low reset (0 = reset)
//   in_data      payload byte
//   in_valid     in_data valid; a byte transfers when in_valid && in_ready
//   in_ready     framer can accept a byte (2-byte collector not full)
//   flush        pad a half-filled collector with 8'h00 and send it
//   data         frame word to the modulator, bit 31 sent first
//   start        one-cycle start pulse to the modulator
//   busy         LOAD, TX or GUARD active
//   frame_count  number of start pulses issued, wraps at 16 bits
// ----------------------------------------------------------------------------
module tx_framer #(
    parameter int         BITS         = 32,
    parameter int         WAVELENGTH   = 4,
    parameter logic [7:0] SYNC         = 8'hA5,
    parameter int         GUARD_CYCLES = 16
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [7:0]      in_data,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic            flush,
    output logic [BITS-1:0] data,
    output logic            start,
    output logic            busy,
    output logic [15:0]     frame_count
);

    localparam int TX_CYCLES = (BITS + 1) * WAVELENGTH;
    localparam int CNT_MAX   = (TX_CYCLES > GUARD_CYCLES) ? TX_CYCLES : GUARD_CYCLES;
    localparam int CNT_W     = $clog2(CNT_MAX + 1);

    localparam logic [CNT_W-1:0] TX_LOAD    = CNT_W'(TX_CYCLES - 1);
    localparam logic [CNT_W-1:0] GUARD_LOAD = CNT_W'(GUARD_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        TX,
        GUARD
    } state_t;

    state_t           state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic             load;

    logic [1:0]       fill;
    logic [7:0]       p0, p1;
    logic             accept;
    logic             pad;

    function automatic logic [7:0] checksum(input logic [7:0] a, input logic [7:0] b);
        return a + b;
    endfunction

    // The ready flag depends only on the collector fill level. This keeps
    // the handshake free of any dependency on the FSM.
    assign in_ready = (fill != 2'd2);
    assign accept   = in_valid && in_ready;
    // A flush matters only when exactly one byte is waiting and no byte
    // arrives in the same cycle to complete the pair.
    assign pad      = flush && (fill == 2'd1) && !accept;

    // Byte collector
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            fill <= 2'd0;
            p0   <= 8'h00;
            p1   <= 8'h00;
        end else if (load) begin
            // Emptying and refilling share an edge so no byte is lost.
            if (accept) begin
                p0   <= in_data;
                fill <= 2'd1;
            end else begin
                fill <= 2'd0;
            end
        end else if (accept) begin
            if (fill == 2'd0) begin
                p0   <= in_data;
                fill <= 2'd1;
            end else begin
                p1   <= in_data;
                fill <= 2'd2;
            end
        end else if (pad) begin
            p1   <= 8'h00;
            fill <= 2'd2;
        end
    end

    // FSM state register and interval counter
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    // Next-state logic; TX and GUARD share one down-counter
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        load      = 1'b0;
        busy      = (state != IDLE);
        case (state)
            IDLE: begin
                if (fill == 2'd2)
                    state_nxt = LOAD;
            end
            LOAD: begin
                load      = 1'b1;
                state_nxt = TX;
                cnt_nxt   = TX_LOAD;
            end
            TX: begin
                if (cnt == '0) begin
                    state_nxt = GUARD;
                    cnt_nxt   = GUARD_LOAD;
                end else begin
                    cnt_nxt = cnt - 1'b1;
                end
            end
            GUARD: begin
                if (cnt == '0)
                    state_nxt = IDLE;
                else
                    cnt_nxt = cnt - 1'b1;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Registered outputs. start and data come straight from flops. This
    // keeps any in_valid/flush change from reaching the modulator in the
    // same cycle.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            data        <= '0;
            start       <= 1'b0;
            frame_count <= 16'h0000;
        end else begin
            start <= load;
            if (load) begin
                data        <= BITS'({SYNC, p0, p1, checksum(p0, p1)});
                frame_count <= frame_count + 16'h0001;
            end
        end
    end

endmodule

// File: tb/tb_tx_framer.sv
module tb_tx_framer;

    localparam int W = 4;
    localparam int G = 16;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [7:0]  in_data = 8'h00;
    logic        in_valid = 1'b0;
    logic        flush = 1'b0;
    wire         in_ready;
    wire [31:0]  data;
    wire         start;
    wire         busy;
    wire [15:0]  frame_count;

    always #5 clk = ~clk;

    tx_framer #(
        .BITS(32), .WAVELENGTH(W), .SYNC(8'hA5), .GUARD_CYCLES(G)
    ) dut (
        .clk(clk), .reset(reset), .in_data(in_data), .in_valid(in_valid),
        .in_ready(in_ready), .flush(flush), .data(data), .start(start),
        .busy(busy), .frame_count(frame_count)
    );

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [31:0] word;
        int          at;
        logic [15:0] cnt;
    } exp_t;

    exp_t        expq[$];
    logic [7:0]  coll[$];
    int          idle_from = 0;
    int          load_at = -1;
    logic [15:0] mcount = 16'h0000;

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic bound_fail(input string name);
        checks++;
        errors++;
        $display("FAIL %s: wait bound expired at cycle %0d", name, cyc);
    endtask

    // One clock cycle of stimulus. The reference model sees frames as byte
    // pairs. When the framer is free and a pair is waiting, that pair
    // becomes a frame whose start pulse appears two cycles later. The
    // framer is then unavailable for load + transmit + guard.
    task automatic step(input bit v, input bit f, input logic [7:0] d, output bit acc);
        int c;
        logic [7:0] ck;
        exp_t e;
        @(negedge clk);
        c = cyc;
        check32("in_ready", {31'd0, in_ready}, {31'd0, coll.size() < 2});
        check32("busy", {31'd0, busy}, {31'd0, c < idle_from});
        in_valid = v;
        flush    = f;
        in_data  = d;
        acc = v && (coll.size() < 2);
        if (c >= idle_from && coll.size() == 2) begin
            ck = 8'((int'(coll[0]) + int'(coll[1])) % 256);
            mcount = mcount + 16'd1;
            e.word = {8'hA5, coll[0], coll[1], ck};
            e.at   = c + 2;
            e.cnt  = mcount;
            expq.push_back(e);
            idle_from = c + 2 + 33 * W + G;
            load_at   = c + 1;
        end
        if (load_at == c) begin
            coll.delete();
            if (acc) coll.push_back(d);
        end else if (acc) begin
            coll.push_back(d);
        end else if (f && coll.size() == 1) begin
            coll.push_back(8'h00);
        end
    endtask

    task automatic send(input logic [7:0] d);
        bit a;
        int n;
        n = 0;
        a = 1'b0;
        while (!a && n < 500) begin
            step(1'b1, 1'b0, d, a);
            n++;
        end
        if (!a) bound_fail("send");
    endtask

    task automatic idle(input int n);
        bit a;
        repeat (n) step(1'b0, 1'b0, 8'($urandom), a);
    endtask

    task automatic drain();
        bit a;
        int n;
        n = 0;
        while ((expq.size() > 0 || coll.size() == 2 || cyc < idle_from + 2) && n < 2000) begin
            step(1'b0, 1'b0, 8'($urandom), a);
            n++;
        end
        if (n >= 2000) bound_fail("drain");
    endtask

    // Monitor: pops one expected frame per start pulse.
    logic [31:0] held = 32'h0;
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (!reset) begin
                held = 32'h0;
            end else if (start) begin
                if (expq.size() == 0) begin
                    bound_fail("unexpected_start");
                end else begin
                    e = expq.pop_front();
                    check32("data", data, e.word);
                    check32("start_cycle", cyc, e.at);
                    held = data;
                    @(negedge clk);
                    check32("frame_count", {16'd0, frame_count}, {16'd0, e.cnt});
                    check32("start_width", {31'd0, start}, 32'd0);
                end
            end else begin
                check32("data_stable", data, held);
            end
        end
    end

    initial begin
        bit a;
        #1;
        check32("rst_data", data, 32'h0);
        check32("rst_start", {31'd0, start}, 32'd0);
        check32("rst_busy", {31'd0, busy}, 32'd0);
        check32("rst_count", {16'd0, frame_count}, 32'd0);
        check32("rst_ready", {31'd0, in_ready}, 32'd1);
        @(negedge clk);
        reset = 1'b1;

        // Basic pair
        send(8'h12); send(8'h34);
        drain();
        // Single byte then flush
        send(8'hFF);
        step(1'b0, 1'b1, 8'h00, a);
        drain();
        // Back-to-back stream
        send(8'h01); send(8'h02); send(8'h03); send(8'h04);
        drain();
        // Flush on empty, then flush coinciding with the completing byte
        step(1'b0, 1'b1, 8'h00, a);
        idle(3);
        send(8'h55);
        step(1'b1, 1'b1, 8'hAA, a);
        drain();

        // Randomized traffic
        for (int i = 0; i < 1500; i++)
            step($urandom_range(0, 9) < 6, $urandom_range(0, 9) == 0, 8'($urandom), a);
        step(1'b0, 1'b1, 8'h00, a);
        drain();

        // Reset mid-transmit
        send(8'h11); send(8'h22);
        idle(40);
        @(negedge clk);
        reset = 1'b0;
        #1;
        check32("mid_rst_data", data, 32'h0);
        check32("mid_rst_start", {31'd0, start}, 32'd0);
        check32("mid_rst_busy", {31'd0, busy}, 32'd0);
        check32("mid_rst_count", {16'd0, frame_count}, 32'd0);
        check32("mid_rst_ready", {31'd0, in_ready}, 32'd1);
        expq.delete();
        coll.delete();
        idle_from = 0;
        load_at = -1;
        mcount = 16'h0000;
        @(negedge clk);
        reset = 1'b1;
        send(8'h80); send(8'h80);
        drain();

        // Counter wrap
        @(negedge clk);
        force dut.frame_count = 16'hFFFF;
        mcount = 16'hFFFF;
        @(negedge clk);
        release dut.frame_count;
        @(negedge clk);
        check32("preload", {16'd0, frame_count}, 32'h0000FFFF);
        send(8'h0F); send(8'hF1);
        drain();
        check32("wrap_count", {16'd0, frame_count}, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/tx_framer.md
TX_FRAMER -- requirements
Module: tx_framer

Interface
REQ-001 Parameters SHALL be: BITS, default 32, width of the modulator word (only 32 is supported); WAVELENGTH, default from core_params, clocks per modulator bit; SYNC, default 8'hA5, frame sync byte; GUARD_CYCLES, default 16, idle clocks between frames.
REQ-002 Ports SHALL be, in order:
  clk  input  1  single clock; all logic on posedge.
  reset  input  1  asynchronous, active-low reset (0 = reset).
  in_data  input  8  payload byte.
  in_valid  input  1  in_data valid.
  in_ready  output  1  framer can accept a byte.
  flush  input  1  send a pending partial frame.
  data  output  BITS  frame word to the modulator.
  start  output  1  one-cycle start pulse to the modulator (drives its reset input).
  busy  output  1  frame transmitting or guard interval active.
  frame_count  output  16  frames issued.

Function
REQ-003 A byte SHALL transfer on a clk edge where in_valid && in_ready.
REQ-004 A 2-byte collector SHALL hold payload bytes P0 then P1; in_ready = (collector count < 2), independent of FSM state.
REQ-005 Bytes SHALL be accepted during TX/GUARD, so the next frame assembles while the current one transmits.
REQ-006 flush with collector count 1 SHALL complete the frame with P1 = 8'h00.
REQ-007 flush with collector count 0 or 2 SHALL be ignored, with no state retained.
REQ-008 flush with count 1 and an accepted byte in the same cycle SHALL take the byte as P1; flush is consumed and no zero pad is inserted.
REQ-009 Frame word SHALL be {SYNC, P0, P1, CK}, with CK = (P0 + P1) mod 256; bit 31 is transmitted first.
REQ-010 FSM states SHALL be IDLE, LOAD, TX, GUARD.
REQ-011 IDLE -> LOAD SHALL occur when the collector is full (count 2, or completed by flush).
REQ-012 LOAD SHALL: register data, empty the collector, and assert start for exactly one cycle, on the cycle after LOAD entry; then go to TX.
REQ-013 TX SHALL last (BITS+1)*WAVELENGTH cycles, counted by a down-counter; then go to GUARD.
REQ-014 GUARD SHALL last GUARD_CYCLES cycles; then go to IDLE.
REQ-015 IDLE with the collector already full SHALL re-enter LOAD on the next cycle.
REQ-016 start SHALL be low for at least GUARD_CYCLES+1 cycles between pulses, so the modulator's rising-edge detect always fires.
REQ-017 data SHALL be stable from the start pulse until the next LOAD.
REQ-018 busy SHALL be 1 in LOAD, TX and GUARD, and 0 in IDLE.
REQ-019 frame_count SHALL increment by 1 on each start pulse, wrapping 16'hFFFF -> 0.
REQ-020 The collector SHALL accept a byte in the same cycle LOAD empties it; that byte becomes the new P0, with no loss or duplication.
REQ-021 The design SHALL have no combinational path from in_valid or flush to start or data.

Reset
REQ-022 When reset = 0, asynchronously: FSM = IDLE, collector emptied, data = 0, start = 0, busy = 0, frame_count = 0, in_ready = 1.
REQ-023 Reset asserted mid-TX SHALL abort the frame immediately; the aborted frame SHALL be neither replayed nor counted again.
REQ-024 After reset release, the first accepted byte SHALL become P0.

Verification
REQ-025 Bytes 8'h12, 8'h34 -> one start pulse; data = 32'hA5123446; frame_count = 1; busy high for 1+(33*WAVELENGTH)+GUARD_CYCLES cycles.
REQ-026 Single byte 8'hFF, then flush -> data = 32'hA5FF00FF.
REQ-027 Four bytes 01,02,03,04 streamed back-to-back -> frames A5010203 then A5030407; second start pulse exactly 1+33*WAVELENGTH+GUARD_CYCLES+1 cycles after the first; in_ready low only while the collector is full.
REQ-028 flush on an empty collector, and 8'hAA accepted in the same cycle as flush with count 1 -> no extra frame; pair becomes {P0, 8'hAA}, with no zero pad.
REQ-029 reset pulled low mid-TX -> all outputs at reset values within the same cycle; next frame 8'h80, 8'h80 -> data = 32'hA5808000, frame_count = 1.
REQ-030 Preload frame_count = 16'hFFFF, send one frame -> frame_count = 0.
